program_loader: RTL

Boot-time instruction loader that sits directly upstream of the single-cycle MIPS core. It receives a framed byte stream (header, big-endian program words, checksum) over a valid/ready interface and writes each assembled 32-bit word into the instruction memory at consecutive word addresses from 0. It holds the core in reset until the whole image has been written and the checksum verified. Because the core's PC advances by 1 per instruction, instruction memory is word-addressed.

---
 rtl/program_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader
// Boot-time instruction loader for the single-cycle MIPS core. Receives a
// framed byte stream {N_hi, N_lo, N x 4 big-endian data bytes, checksum} and
// writes each assembled word to word-addressed instruction memory starting
// at address 0. The core is held in reset until the image has been written
// and its 8-bit additive checksum verified.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  byte-stream handshake, in_data is the stream byte
//   reload          single-cycle abort/restart request
//   imem_we/addr/wdata  registered one-cycle instruction-memory write
//   core_rst        reset to the core, high unless a verified image is present
//   done, error     load verified / load failed (parked until reload or rst)
//   err_code        0 none, 1 bad length, 2 checksum mismatch
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t      state;
  logic [15:0] n_words;
  logic [15:0] word_cnt;
  logic [7:0]  sum;
  logic [1:0]  byte_idx;
  logic [23:0] shreg;
  logic        loading;
  logic        hs;

  // A length of zero or beyond the memory depth is rejected before any write.
  function automatic logic len_ok(input logic [15:0] n);
    return (n != 16'd0) && ({1'b0, n} <= MAX_WORDS);
  endfunction

  always_comb begin
    loading  = (state == S_HDR_HI) || (state == S_HDR_LO) ||
               (state == S_DATA)   || (state == S_CSUM);
    // reload wins over a handshake; dropping ready keeps the byte unconsumed.
    in_ready = loading && !reload;
    hs       = in_valid && in_ready;
  end

  // Byte assembly: only the three leading bytes of a word need storing, the
  // fourth is taken straight from the bus when the word is written.
  always_ff @(posedge clk) begin
    if (hs && state == S_DATA)
      shreg <= {shreg[15:0], in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_HDR_HI;
      n_words    <= '0;
      word_cnt   <= '0;
      sum        <= '0;
      byte_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        state    <= S_HDR_HI;
        n_words  <= '0;
        word_cnt <= '0;
        sum      <= '0;
        byte_idx <= '0;
        core_rst <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
        err_code <= 2'd0;
      end else if (hs) begin
        case (state)
          S_HDR_HI: begin
            n_words[15:8] <= in_data;
            sum           <= sum + in_data;
            state         <= S_HDR_LO;
          end
          S_HDR_LO: begin
            n_words[7:0] <= in_data;
            sum          <= sum + in_data;
            if (!len_ok({n_words[15:8], in_data})) begin
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= 2'd1;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            sum      <= sum + in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_W-1:0];
              imem_wdata <= {shreg, in_data};
              word_cnt   <= word_cnt + 16'd1;
              if (word_cnt + 16'd1 == n_words)
                state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (in_data == sum) begin
              state    <= S_RUN;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= 2'd2;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
